// File: rtl/ins_loader.sv
// ins_loader: host-side program loader for the 256 x 16 instruction memory.
// Consumes a framed byte stream (length, N high/low byte pairs, XOR checksum).
// Each assembled 16-bit word is written to consecutive addresses starting at BASE_ADDR.
// The CPU is held in reset until a load whose checksum matches has finished.
module ins_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [8:0]        word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t      state_r;
  logic [7:0]  len_r;
  logic [7:0]  chk_r;
  logic [7:0]  hi_r;
  logic        accept_s;
  logic [8:0]  count_next_s;

  // Running stream checksum: every framed byte except the checksum itself is folded in.
  function automatic logic [7:0] chk_next(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  // byte_ready is a registered copy of "state takes bytes", so this is a clean handshake.
  assign accept_s     = byte_valid & byte_ready;
  assign count_next_s = word_count + 9'd1;

  // Loader FSM; every output is registered here alongside the state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      len_r      <= 8'd0;
      chk_r      <= 8'd0;
      hi_r       <= 8'd0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 16'd0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= 9'd0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          // A new load re-holds the CPU on the same edge that leaves DONE.
          if (start) begin
            state_r    <= S_LEN;
            word_count <= 9'd0;
            chk_r      <= 8'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_addr   <= BASE_ADDR;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
          end
        end
        S_LEN: begin
          if (accept_s) begin
            len_r <= byte_in;
            chk_r <= byte_in;
            // An empty program goes straight to its checksum byte.
            state_r <= (byte_in == 8'd0) ? S_CSUM : S_HI;
          end
        end
        S_HI: begin
          if (accept_s) begin
            hi_r    <= byte_in;
            chk_r   <= chk_next(chk_r, byte_in);
            state_r <= S_LO;
          end
        end
        S_LO: begin
          if (accept_s) begin
            mem_wdata  <= {hi_r, byte_in};
            chk_r      <= chk_next(chk_r, byte_in);
            mem_we     <= 1'b1;
            // Stall the stream for the single write cycle.
            byte_ready <= 1'b0;
            state_r    <= S_WRITE;
          end
        end
        S_WRITE: begin
          mem_we     <= 1'b0;
          mem_addr   <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          word_count <= count_next_s;
          byte_ready <= 1'b1;
          state_r    <= (count_next_s == {1'b0, len_r}) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          if (accept_s) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_in == chk_r) begin
              state_r  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              // Words already written stay in memory; the CPU stays held.
              state_r  <= S_ERR;
              err      <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          byte_ready <= 1'b0;
          mem_we     <= 1'b0;
          busy       <= 1'b0;
          cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// tb_ins_loader: scoreboard bench for ins_loader.
// Instance u0 uses BASE_ADDR 00 and instance u1 uses BASE_ADDR FE for the wrap case.
// Both instances share the byte bus; each has its own start, so only one loads at a time.
module tb_ins_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;

  logic        byte_ready0, mem_we0, cpu_hold0, busy0, done0, err0;
  logic [7:0]  mem_addr0;
  logic [15:0] mem_wdata0;
  logic [8:0]  word_count0;
  logic        byte_ready1, mem_we1, cpu_hold1, busy1, done1, err1;
  logic [7:0]  mem_addr1;
  logic [15:0] mem_wdata1;
  logic [8:0]  word_count1;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  int          we_cyc[$];
  logic [15:0] wbuf [0:3];

  ins_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) u0 (
    .clk(clk), .reset(reset), .start(start0), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .err(err0), .word_count(word_count0)
  );

  ins_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) u1 (
    .clk(clk), .reset(reset), .start(start1), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .err(err1), .word_count(word_count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write pulse must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    logic [23:0] e;
    if (mem_we0) begin
      total_cnt++;
      we_cyc.push_back(cyc);
      if (q0.size() == 0) begin
        $display("FAIL wr0_unexpected got addr=%h data=%h, no write expected", mem_addr0, mem_wdata0);
      end else begin
        e = q0.pop_front();
        if ({mem_addr0, mem_wdata0} !== e || byte_ready0 !== 1'b0)
          $display("FAIL wr0 got addr=%h data=%h ready=%b, want addr=%h data=%h ready=0",
                   mem_addr0, mem_wdata0, byte_ready0, e[23:16], e[15:0]);
        else pass_cnt++;
      end
    end
    if (mem_we1) begin
      total_cnt++;
      if (q1.size() == 0) begin
        $display("FAIL wr1_unexpected got addr=%h data=%h, no write expected", mem_addr1, mem_wdata1);
      end else begin
        e = q1.pop_front();
        if ({mem_addr1, mem_wdata1} !== e || byte_ready1 !== 1'b0)
          $display("FAIL wr1 got addr=%h data=%h ready=%b, want addr=%h data=%h ready=0",
                   mem_addr1, mem_wdata1, byte_ready1, e[23:16], e[15:0]);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Offer one byte and return at the negedge after it was taken.
  task automatic send_byte(input logic [7:0] b, input int which, input bit gap);
    int n;
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (((which == 0) ? byte_ready0 : byte_ready1) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total_cnt++;
      $display("FAIL send_timeout byte=%h never accepted within 20 cycles", b);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Full framed load of wbuf[0..n-1]; expected writes are queued as bytes go out.
  task automatic run_load(input int which, input int n, input bit bad, input bit gap);
    logic [7:0] chk;
    logic [7:0] base;
    logic [7:0] a;
    base = (which == 0) ? 8'h00 : 8'hFE;
    pulse_start(which);
    chk = n[7:0];
    send_byte(n[7:0], which, gap);
    for (int i = 0; i < n; i++) begin
      a = base + i[7:0];
      if (which == 0) q0.push_back({a, wbuf[i]}); else q1.push_back({a, wbuf[i]});
      chk = chk ^ wbuf[i][15:8] ^ wbuf[i][7:0];
      send_byte(wbuf[i][15:8], which, gap);
      send_byte(wbuf[i][7:0], which, gap);
    end
    send_byte(bad ? (chk ^ 8'h01) : chk, which, gap);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({byte_ready0, mem_we0, cpu_hold0, busy0, done0, err0} !== 6'b001000)
      $display("FAIL reset_flags0 got %b want 001000",
               {byte_ready0, mem_we0, cpu_hold0, busy0, done0, err0});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr0, mem_wdata0, word_count0} !== {8'h00, 16'h0000, 9'd0})
      $display("FAIL reset_regs0 got addr=%h data=%h wc=%0d want 00/0000/0", mem_addr0, mem_wdata0, word_count0);
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr1, cpu_hold1} !== {8'hFE, 1'b1})
      $display("FAIL reset_base1 got addr=%h hold=%b want FE/1", mem_addr1, cpu_hold1);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    we_cyc.delete();
    run_load(0, 2, 1'b0, 1'b1);
    total_cnt++;
    if ({done0, err0, cpu_hold0, busy0, word_count0} !== {4'b1000, 9'd2})
      $display("FAIL basic_status got done=%b err=%b hold=%b busy=%b wc=%0d want 1/0/0/0/2",
               done0, err0, cpu_hold0, busy0, word_count0);
    else pass_cnt++;
    total_cnt++;
    if (we_cyc.size() != 2 || q0.size() != 0)
      $display("FAIL basic_writes got %0d pulses (%0d pending) want 2 (0)", we_cyc.size(), q0.size());
    else pass_cnt++;
  endtask

  task automatic test_bad_checksum;
    we_cyc.delete();
    run_load(0, 2, 1'b1, 1'b1);
    total_cnt++;
    if ({done0, err0, cpu_hold0, word_count0} !== {3'b011, 9'd2} || we_cyc.size() != 2)
      $display("FAIL badchk_status got done=%b err=%b hold=%b wc=%0d pulses=%0d want 0/1/1/2/2",
               done0, err0, cpu_hold0, word_count0, we_cyc.size());
    else pass_cnt++;
    run_load(0, 2, 1'b0, 1'b0);
    total_cnt++;
    if ({done0, err0, cpu_hold0} !== 3'b100)
      $display("FAIL badchk_recover got done=%b err=%b hold=%b want 1/0/0", done0, err0, cpu_hold0);
    else pass_cnt++;
  endtask

  task automatic test_zero_length;
    we_cyc.delete();
    run_load(0, 0, 1'b0, 1'b1);
    total_cnt++;
    if ({done0, err0, cpu_hold0, word_count0} !== {3'b100, 9'd0} || we_cyc.size() != 0)
      $display("FAIL zero_ok got done=%b err=%b hold=%b wc=%0d pulses=%0d want 1/0/0/0/0",
               done0, err0, cpu_hold0, word_count0, we_cyc.size());
    else pass_cnt++;
    run_load(0, 0, 1'b1, 1'b0);
    total_cnt++;
    if ({done0, err0, cpu_hold0} !== 3'b011)
      $display("FAIL zero_bad got done=%b err=%b hold=%b want 0/1/1", done0, err0, cpu_hold0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    wbuf[0] = 16'h0F1E; wbuf[1] = 16'h2D3C; wbuf[2] = 16'h4B5A;
    we_cyc.delete();
    run_load(0, 3, 1'b0, 1'b0);
    total_cnt++;
    if (we_cyc.size() != 3 || we_cyc[1] - we_cyc[0] != 3 || we_cyc[2] - we_cyc[1] != 3)
      $display("FAIL b2b_spacing got %0d pulses spacing %0d,%0d want 3 pulses spacing 3,3",
               we_cyc.size(), (we_cyc.size() > 1) ? we_cyc[1] - we_cyc[0] : -1,
               (we_cyc.size() > 2) ? we_cyc[2] - we_cyc[1] : -1);
    else pass_cnt++;
    total_cnt++;
    if ({done0, word_count0} !== {1'b1, 9'd3})
      $display("FAIL b2b_status got done=%b wc=%0d want 1/3", done0, word_count0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midload;
    pulse_start(0);
    q0.push_back({8'h00, 16'h1234});
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({byte_ready0, mem_we0, cpu_hold0, busy0, done0, err0} !== 6'b001000 ||
        {mem_addr0, mem_wdata0, word_count0} !== {8'h00, 16'h0000, 9'd0})
      $display("FAIL midreset_async got flags=%b addr=%h data=%h wc=%0d want 001000/00/0000/0",
               {byte_ready0, mem_we0, cpu_hold0, busy0, done0, err0}, mem_addr0, mem_wdata0, word_count0);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (q0.size() != 0 || cpu_hold0 !== 1'b1)
      $display("FAIL midreset_after got pending=%0d hold=%b want 0/1", q0.size(), cpu_hold0);
    else pass_cnt++;
    wbuf[0] = 16'hCAFE; wbuf[1] = 16'hBEEF;
    run_load(0, 2, 1'b0, 1'b1);
    total_cnt++;
    if ({done0, cpu_hold0, word_count0} !== {2'b10, 9'd2})
      $display("FAIL midreset_reload got done=%b hold=%b wc=%0d want 1/0/2", done0, cpu_hold0, word_count0);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
    run_load(1, 3, 1'b0, 1'b1);
    total_cnt++;
    if ({done1, err1, cpu_hold1, word_count1, mem_addr1} !== {3'b100, 9'd3, 8'h01} || q1.size() != 0)
      $display("FAIL wrap_status got done=%b err=%b hold=%b wc=%0d addr=%h pending=%0d want 1/0/0/3/01/0",
               done1, err1, cpu_hold1, word_count1, mem_addr1, q1.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_zero_length();
    test_back_to_back();
    test_reset_midload();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
